// File: rtl/audio_pkg.sv
// audio_pkg: shared constants for the sound-effect sequencer.
// Note codes, tone half-periods, effect ROM layout and FSM states.
package audio_pkg;

  localparam int CNT_W = 25;
  localparam int HP_W  = 18;

  typedef logic [3:0] note_t;

  localparam note_t N_REST = 4'd0;
  localparam note_t N_D5   = 4'd1;
  localparam note_t N_D6   = 4'd2;
  localparam note_t N_D7   = 4'd3;
  localparam note_t N_C1   = 4'd4;
  localparam note_t N_C2   = 4'd5;
  localparam note_t N_C3   = 4'd6;

  localparam logic [HP_W-1:0] HP_D5 = 18'd255102;
  localparam logic [HP_W-1:0] HP_D6 = 18'd227273;
  localparam logic [HP_W-1:0] HP_D7 = 18'd202429;
  localparam logic [HP_W-1:0] HP_C1 = 18'd191204;
  localparam logic [HP_W-1:0] HP_C2 = 18'd170358;
  localparam logic [HP_W-1:0] HP_C3 = 18'd151745;

  typedef enum logic [1:0] {
    FX_WIN   = 2'd0,
    FX_ERR   = 2'd1,
    FX_CLICK = 2'd2,
    FX_BG    = 2'd3
  } fx_t;

  localparam logic [3:0] WIN_START   = 4'd0;
  localparam logic [3:0] WIN_LEN     = 4'd4;
  localparam logic [3:0] ERR_START   = 4'd4;
  localparam logic [3:0] ERR_LEN     = 4'd3;
  localparam logic [3:0] CLICK_START = 4'd7;
  localparam logic [3:0] CLICK_LEN   = 4'd1;
  localparam logic [3:0] BG_START    = 4'd8;
  localparam logic [3:0] BG_LEN      = 4'd8;
  localparam logic       BG_LOOP     = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_PLAY,
    ST_GAP
  } state_t;

  function automatic logic [3:0] fx_start(fx_t id);
    unique case (id)
      FX_WIN:   return WIN_START;
      FX_ERR:   return ERR_START;
      FX_CLICK: return CLICK_START;
      FX_BG:    return BG_START;
    endcase
  endfunction

  function automatic logic [3:0] fx_len(fx_t id);
    unique case (id)
      FX_WIN:   return WIN_LEN;
      FX_ERR:   return ERR_LEN;
      FX_CLICK: return CLICK_LEN;
      FX_BG:    return BG_LEN;
    endcase
  endfunction

  function automatic logic [3:0] fx_last(fx_t id);
    return 4'(fx_start(id) + fx_len(id) - 4'd1);
  endfunction

  function automatic logic fx_loops(fx_t id);
    return (id == FX_BG) ? BG_LOOP : 1'b0;
  endfunction

endpackage

// File: rtl/sfx_sequencer_if.sv
// sfx_sequencer_if: game-FSM side request bundle and audio status.
// master = game control, slave = sequencer.
interface sfx_sequencer_if;
  import audio_pkg::*;

  logic [3:0]      req;
  logic            bg_en;
  logic            mute;
  logic            busy;
  logic [1:0]      active_id;
  logic [HP_W-1:0] half_period;
  logic            pwm;

  modport master (
    output req, bg_en, mute,
    input  busy, active_id, half_period, pwm
  );

  modport slave (
    input  req, bg_en, mute,
    output busy, active_id, half_period, pwm
  );

endinterface

// File: rtl/tone_gen.sv
// tone_gen: square-wave generator, toggles pwm every half_period+1 clocks.
// Counter and output are held at zero whenever en is low.
module tone_gen
  import audio_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic [HP_W-1:0] half_period,
  input  logic            en,
  output logic            pwm
);

  logic [HP_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      pwm <= 1'b0;
    end else if (!en) begin
      cnt <= '0;
      pwm <= 1'b0;
    end else if (cnt == half_period) begin
      cnt <= '0;
      pwm <= ~pwm;
    end else begin
      cnt <= cnt + HP_W'(1);
    end
  end

endmodule

// File: rtl/sfx_sequencer.sv
// sfx_sequencer: prioritised sound-effect player driving one PWM pin.
// Pending requests, note ROM, IDLE/LOAD/PLAY/GAP sequencing.
module sfx_sequencer
  import audio_pkg::*;
#(
  parameter int NOTE_CYCLES = 25_000_000,
  parameter int GAP_CYCLES  = 1_000_000
) (
  input logic           clk,
  input logic           rst,
  sfx_sequencer_if.slave bus
);

  localparam logic [CNT_W-1:0] NOTE_LAST = CNT_W'(NOTE_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);

  state_t          state;
  state_t          state_n;
  logic [2:0]      pend;
  fx_t             act;
  fx_t             sel;
  logic [3:0]      addr;
  logic [CNT_W-1:0] cnt;
  logic            elig;
  logic            preempt;
  logic            note_done;
  logic            gap_done;
  logic            at_last;
  logic            playing;
  logic [2:0]      drop;
  logic [2:0]      clr;
  note_t           note;
  logic [HP_W-1:0] hp;
  logic            tone_en;
  logic            tone_pwm;
  logic            unused_req3;

  assign unused_req3 = bus.req[3];

  // Highest pending one-shot wins; background only when nothing pends.
  always_comb begin
    sel = FX_BG;
    if (pend[0])      sel = FX_WIN;
    else if (pend[1]) sel = FX_ERR;
    else if (pend[2]) sel = FX_CLICK;
  end

  assign elig      = (|pend) || bus.bg_en;
  assign preempt   = (|pend) && (sel < act);
  assign note_done = (cnt == NOTE_LAST);
  assign gap_done  = (cnt == GAP_LAST);
  assign at_last   = (addr == fx_last(act));
  assign playing   = (state == ST_PLAY) || (state == ST_GAP);
  assign drop      = playing ? (3'b001 << act) : 3'b000;
  assign clr       = (state == ST_LOAD) ? (3'b001 << sel) : 3'b000;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      ST_IDLE: if (elig) state_n = ST_LOAD;
      ST_LOAD: state_n = ST_PLAY;
      ST_PLAY, ST_GAP: begin
        if (preempt) begin
          state_n = ST_LOAD;
        end else if (act == FX_BG && !bus.bg_en) begin
          state_n = ST_IDLE;
        end else if (state == ST_PLAY) begin
          if (note_done) state_n = ST_GAP;
        end else if (gap_done) begin
          if (!at_last || fx_loops(act)) state_n = ST_PLAY;
          else if (elig)                 state_n = ST_LOAD;
          else                           state_n = ST_IDLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend <= '0;
      act  <= FX_WIN;
      addr <= '0;
      cnt  <= '0;
    end else begin
      pend <= (pend | (bus.req[2:0] & ~drop)) & ~clr;
      unique case (state)
        ST_LOAD: begin
          act  <= sel;
          addr <= fx_start(sel);
          cnt  <= '0;
        end
        ST_PLAY: cnt <= note_done ? '0 : cnt + CNT_W'(1);
        ST_GAP: begin
          if (gap_done) begin
            cnt  <= '0;
            addr <= at_last ? fx_start(act) : addr + 4'd1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: cnt <= '0;
      endcase
    end
  end

  always_comb begin
    unique case (addr)
      4'd0:  note = N_C1;
      4'd1:  note = N_C2;
      4'd2:  note = N_C3;
      4'd3:  note = N_C3;
      4'd4:  note = N_D5;
      4'd5:  note = N_REST;
      4'd6:  note = N_D5;
      4'd7:  note = N_C3;
      4'd8:  note = N_C1;
      4'd9:  note = N_D5;
      4'd10: note = N_D6;
      4'd11: note = N_D5;
      4'd12: note = N_D6;
      4'd13: note = N_C1;
      4'd14: note = N_C2;
      4'd15: note = N_REST;
    endcase
  end

  always_comb begin
    unique case (note)
      N_D5:    hp = HP_D5;
      N_D6:    hp = HP_D6;
      N_D7:    hp = HP_D7;
      N_C1:    hp = HP_C1;
      N_C2:    hp = HP_C2;
      N_C3:    hp = HP_C3;
      default: hp = '0;
    endcase
  end

  assign tone_en = (state == ST_PLAY) && (hp != '0);

  tone_gen u_tone (
    .clk         (clk),
    .rst         (rst),
    .half_period (hp),
    .en          (tone_en),
    .pwm         (tone_pwm)
  );

  // Gating with tone_en drops pwm in the very cycle GAP/IDLE is entered.
  always_comb begin
    bus.busy        = (state != ST_IDLE);
    bus.active_id   = act;
    bus.half_period = (state == ST_PLAY) ? hp : '0;
    bus.pwm         = tone_pwm & tone_en & ~bus.mute;
  end

endmodule

// File: tb/tb_sfx_sequencer.sv
// tb_sfx_sequencer: directed checks on a short-note instance plus
// one full-length instance used for the first pwm edge and mute.
module tb_sfx_sequencer;
  import audio_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_run = 0;
  int   n_fail = 0;

  sfx_sequencer_if bs ();
  sfx_sequencer_if bl ();

  sfx_sequencer #(
    .NOTE_CYCLES (50),
    .GAP_CYCLES  (10)
  ) u_s (
    .clk (clk),
    .rst (rst),
    .bus (bs)
  );

  sfx_sequencer #(
    .NOTE_CYCLES (1_000_000),
    .GAP_CYCLES  (100)
  ) u_l (
    .clk (clk),
    .rst (rst),
    .bus (bl)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step(input int n);
    repeat (n) tick();
  endtask

  initial begin
    bs.req = '0; bs.bg_en = 1'b0; bs.mute = 1'b0;
    bl.req = '0; bl.bg_en = 1'b0; bl.mute = 1'b0;
    step(2);
    chk("rst_busy", bs.busy, 0);
    chk("rst_active", bs.active_id, 0);
    chk("rst_hp", bs.half_period, 0);
    chk("rst_pwm", bs.pwm, 0);
    chk("rst_l_busy", bl.busy, 0);
    rst = 1'b0;
    step(2);

    // click: pend at N, LOAD N+1, PLAY N+2..N+51, GAP N+52..N+61
    bs.req = 4'b0100; tick(); bs.req = '0;
    chk("click_busy_n", bs.busy, 0);
    tick();
    chk("click_busy_n1", bs.busy, 1);
    chk("click_hp_load", bs.half_period, 0);
    tick();
    chk("click_hp_n2", bs.half_period, HP_C3);
    chk("click_active", bs.active_id, 2);
    step(49);
    chk("click_hp_last_play", bs.half_period, HP_C3);
    tick();
    chk("click_hp_gap", bs.half_period, 0);
    chk("click_busy_gap", bs.busy, 1);
    step(9);
    chk("click_busy_gap_end", bs.busy, 1);
    tick();
    chk("click_idle", bs.busy, 0);

    // error: D5, rest, D5 at 60-cycle spacing
    bs.req = 4'b0010; tick(); bs.req = '0;
    step(2);
    chk("err_active", bs.active_id, 1);
    chk("err_hp0", bs.half_period, HP_D5);
    step(50);
    chk("err_gap0", bs.half_period, 0);
    step(10);
    chk("err_hp1_rest", bs.half_period, 0);
    chk("err_busy_rest", bs.busy, 1);
    chk("err_pwm_rest", bs.pwm, 0);
    step(60);
    chk("err_hp2", bs.half_period, HP_D5);
    step(60);
    chk("err_idle", bs.busy, 0);

    // background: LOAD on the bg_en edge, ninth note loops to C1
    bs.bg_en = 1'b1; tick();
    chk("bg_busy", bs.busy, 1);
    tick();
    chk("bg_active", bs.active_id, 3);
    chk("bg_note0", bs.half_period, HP_C1);
    step(60);
    chk("bg_note1", bs.half_period, HP_D5);
    step(360);
    chk("bg_note7_rest", bs.half_period, 0);
    step(60);
    chk("bg_note8_loop", bs.half_period, HP_C1);
    bs.bg_en = 1'b0; tick();
    chk("bg_off_busy", bs.busy, 0);
    chk("bg_off_pwm", bs.pwm, 0);
    chk("bg_off_hp", bs.half_period, 0);

    // background preempted by win mid-note, then restarts at C1
    bs.bg_en = 1'b1; tick();
    tick();
    step(70);
    chk("pre_bg_note1", bs.half_period, HP_D5);
    bs.req = 4'b0001; tick(); bs.req = '0;
    chk("pre_still_play", bs.half_period, HP_D5);
    tick();
    chk("pre_load_busy", bs.busy, 1);
    chk("pre_load_hp", bs.half_period, 0);
    tick();
    chk("pre_win_active", bs.active_id, 0);
    chk("pre_win_n0", bs.half_period, HP_C1);
    step(60);
    chk("pre_win_n1", bs.half_period, HP_C2);
    step(60);
    chk("pre_win_n2", bs.half_period, HP_C3);
    step(60);
    chk("pre_win_n3", bs.half_period, HP_C3);
    step(60);
    chk("pre_reload_busy", bs.busy, 1);
    chk("pre_reload_hp", bs.half_period, 0);
    tick();
    chk("pre_bg_active", bs.active_id, 3);
    chk("pre_bg_restart", bs.half_period, HP_C1);
    bs.bg_en = 1'b0; tick();
    chk("pre_bg_off", bs.busy, 0);

    // win+click together: win, then click; repeat click is dropped
    bs.req = 4'b0101; tick(); bs.req = '0;
    step(2);
    chk("dual_win_active", bs.active_id, 0);
    chk("dual_win_hp", bs.half_period, HP_C1);
    step(240);
    chk("dual_load_busy", bs.busy, 1);
    chk("dual_load_hp", bs.half_period, 0);
    tick();
    chk("dual_click_active", bs.active_id, 2);
    chk("dual_click_hp", bs.half_period, HP_C3);
    bs.req = 4'b0100; tick(); bs.req = '0;
    step(59);
    chk("dual_idle", bs.busy, 0);
    step(5);
    chk("dual_no_replay", bs.busy, 0);

    // mute during win; async reset mid-click drops a pending error
    bs.mute = 1'b1;
    bs.req = 4'b0101; tick(); bs.req = '0;
    step(2);
    chk("mute_hp0", bs.half_period, HP_C1);
    chk("mute_pwm0", bs.pwm, 0);
    step(60);
    chk("mute_hp1", bs.half_period, HP_C2);
    step(181);
    chk("rstm_click_active", bs.active_id, 2);
    bs.req = 4'b0010; tick(); bs.req = '0;
    #1 rst = 1'b1;
    #1;
    chk("rstm_busy", bs.busy, 0);
    chk("rstm_active", bs.active_id, 0);
    chk("rstm_hp", bs.half_period, 0);
    chk("rstm_pwm", bs.pwm, 0);
    rst = 1'b0;
    bs.mute = 1'b0;
    step(5);
    chk("rstm_pend_lost", bs.busy, 0);

    // full-length click: first pwm rise at N+2+151745+1
    bl.req = 4'b0100; tick(); bl.req = '0;
    step(2);
    chk("long_hp", bl.half_period, HP_C3);
    chk("long_pwm_start", bl.pwm, 0);
    step(151745);
    chk("long_pwm_before", bl.pwm, 0);
    tick();
    chk("long_pwm_rise", bl.pwm, 1);
    bl.mute = 1'b1;
    #1;
    chk("long_mute_pwm", bl.pwm, 0);
    chk("long_mute_hp", bl.half_period, HP_C3);
    bl.mute = 1'b0;
    #1;
    chk("long_unmute_pwm", bl.pwm, 1);
    tick();
    chk("long_pwm_hold", bl.pwm, 1);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
